// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared ALU. It grants one requester at a time.
// Operands and the opcode go to the ALU through registers. The ALU result is
// registered and held until the owner accepts it.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]      req_op,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_result,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [1:0]                alu_op,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, next_state;

  logic [IDX_W-1:0] owner, last_owner, winner, scan_idx;
  logic             found;

  // Packed per-requester views of the flattened operand buses.
  logic [NUM_REQ-1:0][DATA_W-1:0] a_vec, b_vec;
  logic [NUM_REQ-1:0][1:0]        op_vec;

  assign a_vec  = req_a;
  assign b_vec  = req_b;
  assign op_vec = req_op;

  // Round-robin scan. It starts just after the last owner and wraps around.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Next-state logic and handshake outputs. Ready is only offered from IDLE.
  always_comb begin
    next_state = state;
    req_ready  = '0;
    resp_valid = '0;
    case (state)
      IDLE: begin
        if (found && !rst) begin
          req_ready  = NUM_REQ'(1) << winner;
          next_state = EXEC;
        end
      end
      EXEC: next_state = RESP;
      RESP: begin
        resp_valid = NUM_REQ'(1) << owner;
        if (resp_ready[owner]) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Datapath registers. Operands are captured on accept, the result is captured
  // in EXEC, and the pointer advances when the response is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= 2'b00;
      resp_result <= '0;
      owner       <= '0;
      last_owner  <= LAST_INIT;
    end else begin
      case (state)
        IDLE: if (found) begin
          alu_a  <= a_vec[winner];
          alu_b  <= b_vec[winner];
          alu_op <= op_vec[winner];
          owner  <= winner;
        end
        EXEC: resp_result <= alu_result;
        RESP: if (resp_ready[owner]) last_owner <= owner;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
